main_mem_responder: RTL

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder_pkg.sv | 7 +
 rtl/main_mem_responder_line_ram.sv | 22 ++
 rtl/riscv_define.v | 7 +
 rtl/main_mem_responder.sv | 92 +++++++++
 4 files changed

// File: rtl/main_mem_responder_pkg.sv
// main_mem_responder_pkg: states and bus widths shared by the responder and its line RAM.
`include "riscv_define.v"
package main_mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;
  localparam int LINE_W = `MEM_LINE_WIDTH;
  localparam int ADDR_W = `MEM_ADDR_WIDTH;
endpackage

// File: rtl/main_mem_responder_line_ram.sv
// line_ram: DEPTH x LINE_W array with one synchronous read/write port (read-before-write).
module line_ram
  import main_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/riscv_define.v
// riscv_define: shared memory-bus widths for the main memory path.
`ifndef MEM_LINE_WIDTH
`define MEM_LINE_WIDTH 128
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency line memory responder (IDLE/BUSY/RESP/GAP).
// Define MEM_BOUNDS_CHECK_EN to add mem_err and drop out-of-range accesses instead of wrapping.
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] mem_resp_addr,
  output logic              busy
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic              mem_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic we_q;
  logic [ADDR_W-5:0] line_q, op_line;
  logic [LINE_W-1:0] wdata_q, op_wdata, ram_rdata;
  logic accept, ram_en, op_we, op_err, resp_err, unused_bits;
  assign accept = state == IDLE && mem_req;
  // With LATENCY=1 the RAM access happens on the acceptance edge, so it must see live inputs.
  assign op_line  = state == IDLE ? mem_addr[ADDR_W-1:4] : line_q;
  assign op_we    = state == IDLE ? mem_we : we_q;
  assign op_wdata = state == IDLE ? mem_wdata : wdata_q;
  assign ram_en   = rst_n && ((accept && LATENCY == 1) || (state == BUSY && cnt == CW'(1)));
  assign unused_bits = ^{mem_addr[3:0], op_line};
`ifdef MEM_BOUNDS_CHECK_EN
  assign op_err   = |op_line[ADDR_W-5:AW];
  assign resp_err = |line_q[ADDR_W-5:AW];
  assign mem_err  = state == RESP && resp_err;
`else
  assign op_err   = 1'b0;
  assign resp_err = 1'b0;
`endif
  line_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (op_we && !op_err),
    .addr  (op_line[AW-1:0]),
    .wdata (op_wdata),
    .rdata (ram_rdata)
  );
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (mem_req) begin
        state_nx = LATENCY == 1 ? RESP : BUSY;
        cnt_nx   = CW'(LATENCY - 1);
      end
      BUSY: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = RESP;
      end
      RESP:    state_nx = GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      line_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= mem_we;
        line_q  <= mem_addr[ADDR_W-1:4];
        wdata_q <= mem_wdata;
      end
    end
  end
  assign busy          = state != IDLE;
  assign mem_ready     = state == RESP;
  assign mem_resp_addr = state == RESP ? {line_q, 4'b0} : '0;
  assign mem_rdata     = state == RESP && !we_q && !resp_err ? ram_rdata : '0;
endmodule
